// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, word-length codes and helpers
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} tx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [3:0] wordlen(input logic [1:0] wls);
        return wls == WLS_8 ? 4'd8 : wls == WLS_7 ? 4'd7 : wls == WLS_6 ? 4'd6 : 4'd5;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: oversample counter with terminal and half-period ticks
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clken,
    input  logic clr,
    output logic term,
    output logic half
);
    localparam int W = $clog2(OVERSAMPLE);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : clken ? cnt_q + 1'b1 : cnt_q;
        term  = clken && cnt_q == W'(OVERSAMPLE - 1);
        half  = clken && cnt_q == W'(OVERSAMPLE / 2 - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART 16750 transmit serializer (start, data, parity, stop)
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_MAX   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLKEN,
    input  logic [1:0]          WLS,
    input  logic                STB,
    input  logic                PEN,
    input  logic                EPS,
    input  logic                SP,
    input  logic                BC,
    input  logic                TXSTART,
    input  logic [DATA_MAX-1:0] DIN,
    output logic                TXFINISHED,
    output logic                SOUT
);
    localparam int BW = $clog2(DATA_MAX);

    tx_state_t           state_q, state_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_MAX-1:0] sh_q, sh_d, msk;
    logic [1:0]          wls_q, wls_d;
    logic                stb_q, stb_d, pen_q, pen_d, par_q, par_d, ext_q, ext_d;
    logic                sout_q, sout_d, fin_q, fin_d;
    logic                clr, term, half, last;

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clk  (CLK),
        .rst  (RST),
        .clken(CLKEN),
        .clr  (clr),
        .term (term),
        .half (half)
    );

    always_comb begin
        for (int i = 0; i < DATA_MAX; i++) msk[i] = i < int'(wordlen(WLS));
    end

    assign last = int'(bit_q) == int'(wordlen(wls_q)) - 1;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        wls_d   = wls_q;
        stb_d   = stb_q;
        pen_d   = pen_q;
        par_d   = par_q;
        ext_d   = ext_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (TXSTART) begin
                    state_d = START;
                    sh_d    = DIN;
                    wls_d   = WLS;
                    stb_d   = STB;
                    pen_d   = PEN;
                    par_d   = SP ? ~EPS : (^(DIN & msk)) ^ ~EPS;
                    bit_d   = '0;
                    ext_d   = 1'b0;
                end
            end
            START:  if (term) state_d = DATA;
            DATA: if (term) begin
                state_d = last ? (pen_q ? PARITY : STOP) : DATA;
                bit_d   = last ? bit_q : bit_q + 1'b1;
                sh_d    = sh_q >> 1;
            end
            PARITY: if (term) state_d = STOP;
            // 1.5 stop bits: one full period, then wait for the half-period tick
            STOP: begin
                if (ext_q && half) state_d = IDLE;
                else if (term) begin
                    if (!stb_q)              state_d = IDLE;
                    else if (wls_q == WLS_5) ext_d = 1'b1;
                    else                     state_d = STOP2;
                end
            end
            STOP2:  if (term) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        sout_d = BC ? 1'b0 : state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] :
                 state_d == PARITY ? par_q : 1'b1;
        fin_d  = state_q != IDLE && state_d == IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            wls_q   <= WLS_5;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            ext_q   <= 1'b0;
            sout_q  <= 1'b1;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            wls_q   <= wls_d;
            stb_q   <= stb_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            ext_q   <= ext_d;
            sout_q  <= sout_d;
            fin_q   <= fin_d;
        end
    end

    assign SOUT       = sout_q;
    assign TXFINISHED = fin_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed frame checks of the UART transmit serializer
module tb_uart_tx_core;
    import uart_pkg::*;

    logic       clk, RST, CLKEN, STB, PEN, EPS, SP, BC, TXSTART, TXFINISHED, SOUT;
    logic [1:0] WLS;
    logic [7:0] DIN;
    int         n_chk, n_pass, ccnt;

    uart_tx_core #(.OVERSAMPLE(16), .DATA_MAX(8)) dut (
        .CLK       (clk),
        .RST       (RST),
        .CLKEN     (CLKEN),
        .WLS       (WLS),
        .STB       (STB),
        .PEN       (PEN),
        .EPS       (EPS),
        .SP        (SP),
        .BC        (BC),
        .TXSTART   (TXSTART),
        .DIN       (DIN),
        .TXFINISHED(TXFINISHED),
        .SOUT      (SOUT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int div);
        CLKEN = (ccnt % div) == 0;
        @(posedge clk);
        #1;
        ccnt++;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] din, input logic [1:0] wls,
                             input logic pen, input logic eps, input logic sp, input logic stb,
                             input logic pbit, input int div, input int exp_cyc,
                             input logic nxt, input logic [7:0] nxt_din,
                             input int b0, input int b1, input int abort);
        logic sv[16];
        int   st[16];
        int   ns, idx, tk, cyc;
        logic es, ef;
        ns = 0;
        sv[ns] = 1'b0; st[ns] = 16; ns++;
        for (int k = 0; k < 5 + int'(wls); k++) begin sv[ns] = din[k]; st[ns] = 16; ns++; end
        if (pen) begin sv[ns] = pbit; st[ns] = 16; ns++; end
        sv[ns] = 1'b1; st[ns] = (stb && wls == 2'b00) ? 24 : 16; ns++;
        if (stb && wls != 2'b00) begin sv[ns] = 1'b1; st[ns] = 16; ns++; end
        DIN = din; WLS = wls; PEN = pen; EPS = eps; SP = sp; STB = stb; BC = 1'b0;
        TXSTART = 1'b1;
        step(1);
        TXSTART = nxt; DIN = nxt_din;
        WLS = ~wls; PEN = ~pen; EPS = ~eps; SP = ~sp; STB = ~stb;
        ccnt = 0; idx = 0; tk = 0;
        for (cyc = 1; cyc <= 2000; cyc++) begin
            BC = cyc >= b0 && cyc < b1;
            step(div);
            if (CLKEN) begin
                tk++;
                if (tk == st[idx]) begin idx++; tk = 0; end
            end
            ef = idx == ns;
            es = BC ? 1'b0 : ef ? 1'b1 : sv[idx];
            check({tag, " sout"}, 32'(SOUT), 32'(es));
            check({tag, " fin"}, 32'(TXFINISHED), 32'(ef));
            if (ef || cyc == abort) break;
        end
        BC = 1'b0; WLS = wls; PEN = pen; EPS = eps; SP = sp; STB = stb;
        if (abort == 0) check({tag, " len"}, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        n_chk = 0; n_pass = 0; ccnt = 0;
        RST = 1'b1; CLKEN = 1'b0; WLS = 2'b11; STB = 1'b0; PEN = 1'b0; EPS = 1'b0;
        SP = 1'b0; BC = 1'b0; TXSTART = 1'b0; DIN = 8'h00;
        step(1); step(1);
        check("rst sout", 32'(SOUT), 32'd1);
        check("rst fin", 32'(TXFINISHED), 32'd0);
        check("rst state", 32'(dut.state_q), 32'(IDLE));
        RST = 1'b0;
        step(1); step(1);
        check("idle sout", 32'(SOUT), 32'd1);

        run_frame("8N1 55", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 160, 1'b0, 8'h00, 0, 0, 0);
        step(1);
        run_frame("7E2 03", 8'h03, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 176, 1'b0, 8'h00, 0, 0, 0);
        step(1);
        run_frame("5N1.5 1F", 8'h1F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 477, 1'b0, 8'h00, 0, 0, 0);
        step(1);
        run_frame("6E1 47", 8'h47, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 144, 1'b0, 8'h00, 0, 0, 0);
        step(1);
        run_frame("8O1 0F", 8'h0F, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 176, 1'b0, 8'h00, 0, 0, 0);
        step(1);
        run_frame("stick e0 00", 8'h00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 176, 1'b0, 8'h00, 0, 0, 0);
        run_frame("stick e0 ff", 8'hFF, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 176, 1'b0, 8'h00, 0, 0, 0);
        run_frame("stick e1 00", 8'h00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 176, 1'b0, 8'h00, 0, 0, 0);
        run_frame("stick e1 ff", 8'hFF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 176, 1'b0, 8'h00, 0, 0, 0);
        step(1);
        run_frame("b2b A5", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 160, 1'b1, 8'h3C, 0, 0, 0);
        run_frame("b2b 3C", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 160, 1'b0, 8'h00, 0, 0, 0);
        step(1);
        run_frame("break", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 160, 1'b0, 8'h00, 30, 70, 0);
        step(1);
        run_frame("abort", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 8'h00, 0, 0, 40);
        #2 RST = 1'b1;
        #1;
        check("async rst sout", 32'(SOUT), 32'd1);
        check("async rst fin", 32'(TXFINISHED), 32'd0);
        check("async rst state", 32'(dut.state_q), 32'(IDLE));
        step(1);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("post rst fin", 32'(TXFINISHED), 32'd0);
            check("post rst sout", 32'(SOUT), 32'd1);
        end
        run_frame("recover", 8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 160, 1'b0, 8'h00, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Transmit serializer for the UART 16750. It is the sending end of the same line protocol the receive path decodes.
- Takes one character from the THR/TX FIFO front end and shifts it out on SOUT: start bit, 5–8 data bits LSB first, optional parity, then 1, 1.5 or 2 stop bits.
- Bit timing comes from the 16x baud enable (CLKEN) produced by the divisor-latch baud generator.
- Reports completion to the FIFO/THR logic, which drives the THRE/TEMT status and interrupts.

Parameters:
- OVERSAMPLE, 16, CLKEN pulses per bit period; power of 2, minimum 4.
- DATA_MAX, 8, width of DIN and maximum word length.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- CLKEN  input  1  baud enable, one CLK wide, at OVERSAMPLE x baud rate.
- WLS  input  2  word length select (LCR[1:0]): 00=5, 01=6, 10=7, 11=8 bits.
- STB  input  1  stop bits (LCR[2]): 0=1 stop bit; 1=1.5 stop bits if WLS=00, otherwise 2.
- PEN  input  1  parity enable (LCR[3]).
- EPS  input  1  even parity select (LCR[4]).
- SP  input  1  stick parity (LCR[5]).
- BC  input  1  break control (LCR[6]).
- TXSTART  input  1  start request, level, sampled only in IDLE.
- DIN  input  DATA_MAX  character to send.
- TXFINISHED  output  1  one-CLK pulse when a frame completes.
- SOUT  output  1  serial output, registered.

Behaviour:
- Reset: state=IDLE, bit timer=0, bit counter=0, shift register=0, SOUT=1, TXFINISHED=0. An asserted RST mid-frame aborts the frame immediately. SOUT returns to 1 asynchronously and no TXFINISHED is issued.
- States (tx_state_t): IDLE, START, DATA, PARITY, STOP, STOP2.
- IDLE:
  - On a CLK edge with TXSTART=1: capture DIN and the WLS/STB/PEN/EPS/SP configuration, clear the bit timer, go to START.
  - LCR changes during a frame do not affect that frame.
- Bit timer: increments on CLKEN. Each state holds for OVERSAMPLE CLKEN pulses. The state advances on the CLKEN at which the timer equals OVERSAMPLE-1, then the timer wraps to 0. The first timer period after START entry may be short by up to one CLKEN interval, which is accepted.
- Transitions:
  - START → DATA.
  - DATA: emits bit[n] with n=0..wordlen-1, shifting after each bit. Goes to PARITY if PEN=1, otherwise to STOP, after the last bit.
  - PARITY → STOP.
  - STOP:
    - STB=0: go to IDLE after OVERSAMPLE ticks.
    - STB=1, 5-bit word: go to IDLE after 3*OVERSAMPLE/2 ticks.
    - STB=1, other word lengths: go to STOP2.
  - STOP2 → IDLE after OVERSAMPLE ticks.
- SOUT per state: IDLE=1, START=0, DATA=current LSB, PARITY=parity bit, STOP/STOP2=1. SOUT updates on the same edge as the state change.
- Parity (XOR over the active wordlen bits only):
  - SP=0: parity = XOR ^ ~EPS (EPS=1 gives even parity).
  - SP=1: parity = ~EPS (stick parity).
- Break: while BC=1, SOUT is forced to 0. The state machine keeps running unaffected. When BC drops, SOUT resumes its state value on the next edge.
- TXFINISHED: high for exactly one CLK on the edge where the state returns to IDLE.
  - TXSTART held high in that cycle is accepted on the following edge, so back-to-back frames have no idle bit.
  - TXSTART asserted outside IDLE is ignored and not queued.
- CLKEN=0 permanently: the machine freezes in its current state and SOUT holds.

Decomposition:
- Package uart_pkg:
  - tx_state_t (enum logic [2:0]).
  - WLS encodings as localparams WLS_5..WLS_8.
  - Function wordlen(WLS) returning 5..8.
- Sub-module uart_bit_timer: OVERSAMPLE counter with CLKEN input, synchronous clear, and terminal/half-terminal outputs. It is reused by the receive path for mid-bit sampling.

Test Plan:
- 8N1, DIN=0x55, CLKEN tied 1, TXSTART pulsed 1 cycle:
  - SOUT sequence is 0,1,0,1,0,1,0,1,0,1, each held 16 cycles.
  - TXFINISHED pulses 160 cycles after TXSTART is sampled.
- 7E2 (WLS=10, PEN=1, EPS=1, STB=1), DIN=0x03:
  - Frame is start, 1100000, parity=0, stop, stop; 11 bit periods, 176 cycles.
- 5-bit, STB=1, CLKEN every 4th CLK, DIN=0x1F:
  - Stop bit lasts 24 CLKEN = 96 CLK.
  - Total frame is 7.5 bit periods.
- Stick parity, SP=1, PEN=1, EPS=0 and EPS=1, DIN=0x00 and 0xFF:
  - Parity bit is 1 for EPS=0 and 0 for EPS=1, independent of the data.
- TXSTART held high for 2 frames with DIN=0xA5 then 0x3C:
  - Second start bit begins on the cycle after the first TXFINISHED.
  - No idle gap; 2 TXFINISHED pulses.
- BC=1 mid-frame, then RST asserted mid-frame:
  - SOUT=0 during break while the frame timing is unchanged.
  - On RST, SOUT=1 and state=IDLE asynchronously, with no TXFINISHED pulse.
